// File: rtl/servo_pkg.sv
// Shared types and default timing constants for the servo PWM generator.
package servo_pkg;

    localparam int unsigned PERIOD_TICKS  = 800;
    localparam int unsigned MIN_TICKS     = 40;
    localparam int unsigned SPAN_TICKS    = 40;
    localparam int unsigned NEUTRAL_TICKS = 60;
    localparam int unsigned POS_W         = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/servo_pwm_gen.sv
// Servo frame generator: one pulse of active_w ticks per PERIOD_TICKS frame,
// with a one-deep pending slot so width updates only land on frame boundaries.
module servo_pwm_gen #(
    parameter int unsigned PERIOD_TICKS  = servo_pkg::PERIOD_TICKS,
    parameter int unsigned MIN_TICKS     = servo_pkg::MIN_TICKS,
    parameter int unsigned SPAN_TICKS    = servo_pkg::SPAN_TICKS,
    parameter int unsigned NEUTRAL_TICKS = servo_pkg::NEUTRAL_TICKS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tick,
    input  logic                        en,
    input  logic [servo_pkg::POS_W-1:0] pos_data,
    input  logic                        pos_valid,
    output logic                        pos_ready,
    output logic                        pwm_out,
    output logic                        frame_start,
    output logic                        sat
);
    import servo_pkg::state_t;
    import servo_pkg::IDLE;
    import servo_pkg::HIGH;
    import servo_pkg::LOW;

    localparam int unsigned CNT_W = $clog2(PERIOD_TICKS);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CNT_W-1:0] active_w, active_d;
    logic [CNT_W-1:0] pend_w, pend_w_d;
    logic             pend_full, pend_full_d;
    logic             pwm_d, frame_start_d, sat_d;
    logic             boundary;
    logic             accept;
    logic             over_span;
    logic [CNT_W-1:0] cap_w;

    // Clamp the requested offset into the legal span before it is stored.
    assign over_span = (32'(pos_data) > SPAN_TICKS);
    assign cap_w     = CNT_W'(MIN_TICKS) +
                       (over_span ? CNT_W'(SPAN_TICKS) : CNT_W'(pos_data));
    assign accept    = pos_valid && !pend_full;

    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        pwm_d         = pwm_out;
        active_d      = active_w;
        pend_w_d      = pend_w;
        pend_full_d   = pend_full;
        sat_d         = sat;
        boundary      = 1'b0;

        case (state)
            IDLE: begin
                pwm_d = 1'b0;
                if (tick && en) begin
                    boundary = 1'b1;
                    cnt_d    = '0;
                    pwm_d    = 1'b1;
                    state_d  = HIGH;
                end
            end
            HIGH, LOW: begin
                if (tick) begin
                    if (cnt == CNT_W'(PERIOD_TICKS - 1)) begin
                        boundary = 1'b1;
                        cnt_d    = '0;
                        if (en) begin
                            pwm_d   = 1'b1;
                            state_d = HIGH;
                        end else begin
                            pwm_d   = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                        if (cnt + CNT_W'(1) == active_w) begin
                            pwm_d   = 1'b0;
                            state_d = LOW;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                pwm_d   = 1'b0;
            end
        endcase

        frame_start_d = boundary;

        // Pending width is promoted only at a boundary so a frame never changes width.
        if (boundary && pend_full) begin
            active_d    = pend_w;
            pend_full_d = 1'b0;
        end

        // A capture landing on a boundary with an empty slot goes straight to the new frame.
        if (accept) begin
            sat_d = over_span;
            if (boundary) begin
                active_d = cap_w;
            end else begin
                pend_w_d    = cap_w;
                pend_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            pwm_out     <= 1'b0;
            frame_start <= 1'b0;
            active_w    <= CNT_W'(NEUTRAL_TICKS);
            pend_w      <= '0;
            pend_full   <= 1'b0;
            pos_ready   <= 1'b1;
            sat         <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            pwm_out     <= pwm_d;
            frame_start <= frame_start_d;
            active_w    <= active_d;
            pend_w      <= pend_w_d;
            pend_full   <= pend_full_d;
            pos_ready   <= !pend_full_d;
            sat         <= sat_d;
        end
    end

endmodule
